// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles the bus-side signals of the instruction-fetch sequencer:
//   ICache request/response, branch-predictor lookup, instruction-queue push
//   and the ROB redirect.
//
//   master : the fetch sequencer (drives ic_req/ic_addr, bp_pc/bp_instr, iq_*)
//   slave  : the surrounding pipeline (ICache, predictor, IQ, ROB)
//
//   ic_req / ic_addr        fetch request and address (registered)
//   ic_valid / ic_instr     ICache response pulse and instruction
//   bp_pc / bp_instr        lookup presented to the predictor
//   bp_taken/bp_predict_pc  predictor decision and target
//   iq_full                 IQ back-pressure
//   iq_push / iq_*          IQ push strobe and payload
//   flush / flush_pc        ROB misprediction redirect
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ic_req;
    logic [DATA_WIDTH-1:0] ic_addr;
    logic                  ic_valid;
    logic [DATA_WIDTH-1:0] ic_instr;

    logic [DATA_WIDTH-1:0] bp_pc;
    logic [DATA_WIDTH-1:0] bp_instr;
    logic                  bp_taken;
    logic [DATA_WIDTH-1:0] bp_predict_pc;

    logic                  iq_full;
    logic                  iq_push;
    logic [DATA_WIDTH-1:0] iq_instr;
    logic [DATA_WIDTH-1:0] iq_pc;
    logic                  iq_pred_taken;
    logic [DATA_WIDTH-1:0] iq_pred_pc;

    logic                  flush;
    logic [DATA_WIDTH-1:0] flush_pc;

    modport master (
        output ic_req, ic_addr,
        input  ic_valid, ic_instr,
        output bp_pc, bp_instr,
        input  bp_taken, bp_predict_pc,
        input  iq_full,
        output iq_push, iq_instr, iq_pc, iq_pred_taken, iq_pred_pc,
        input  flush, flush_pc
    );

    modport slave (
        input  ic_req, ic_addr,
        output ic_valid, ic_instr,
        input  bp_pc, bp_instr,
        output bp_taken, bp_predict_pc,
        output iq_full,
        input  iq_push, iq_instr, iq_pc, iq_pred_taken, iq_pred_pc,
        output flush, flush_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   IF-stage fetch sequencer. Holds the fetch PC, issues one ICache request
//   at a time, routes each returned instruction through the branch predictor
//   and pushes {instr, pc, prediction} into the instruction queue. The next
//   PC comes from the prediction; a ROB flush redirects it.
//
//   clk    : system clock
//   reset  : asynchronous, active-low reset
//   rdy    : global ready; 0 freezes every register and ignores inputs
//   bus    : fetch_ctrl_if.master (ICache, predictor, IQ, flush signals)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rdy,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  ic_req_q, ic_req_d;
    logic [DATA_WIDTH-1:0] ic_addr_q, ic_addr_d;

    logic                  iq_push_q, iq_push_d;
    logic [DATA_WIDTH-1:0] iq_instr_q, iq_instr_d;
    logic [DATA_WIDTH-1:0] iq_pc_q, iq_pc_d;
    logic                  iq_taken_q, iq_taken_d;
    logic [DATA_WIDTH-1:0] iq_pred_q, iq_pred_d;

    // Response parked here while the IQ is full.
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [DATA_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic                  hold_taken_q, hold_taken_d;
    logic [DATA_WIDTH-1:0] hold_nxt_q, hold_nxt_d;

    logic [DATA_WIDTH-1:0] nxt_pc;

    // Predictor sees the in-flight address and the returning instruction.
    assign bus.bp_pc    = ic_addr_q;
    assign bus.bp_instr = bus.ic_instr;

    assign bus.ic_req        = ic_req_q;
    assign bus.ic_addr       = ic_addr_q;
    assign bus.iq_push       = iq_push_q;
    assign bus.iq_instr      = iq_instr_q;
    assign bus.iq_pc         = iq_pc_q;
    assign bus.iq_pred_taken = iq_taken_q;
    assign bus.iq_pred_pc    = iq_pred_q;

    assign nxt_pc = bus.bp_taken ? bus.bp_predict_pc
                                 : ic_addr_q + DATA_WIDTH'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ic_req_d     = ic_req_q;
        ic_addr_d    = ic_addr_q;
        iq_push_d    = 1'b0;
        iq_instr_d   = iq_instr_q;
        iq_pc_d      = iq_pc_q;
        iq_taken_d   = iq_taken_q;
        iq_pred_d    = iq_pred_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        hold_taken_d = hold_taken_q;
        hold_nxt_d   = hold_nxt_q;

        if (bus.flush) begin
            pc_d         = bus.flush_pc;
            ic_req_d     = 1'b0;
            hold_instr_d = '0;
            hold_pc_d    = '0;
            hold_taken_d = 1'b0;
            hold_nxt_d   = '0;
            unique case (state_q)
                // A request still in flight must be drained; if its
                // response lands this very cycle it is simply dropped.
                ST_WAIT, ST_DRAIN: state_d = bus.ic_valid ? ST_IDLE : ST_DRAIN;
                default:           state_d = ST_IDLE;
            endcase
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    ic_req_d  = 1'b1;
                    ic_addr_d = pc_q;
                    state_d   = ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.ic_valid) begin
                        pc_d     = nxt_pc;
                        ic_req_d = 1'b0;
                        if (!bus.iq_full) begin
                            iq_push_d  = 1'b1;
                            iq_instr_d = bus.ic_instr;
                            iq_pc_d    = ic_addr_q;
                            iq_taken_d = bus.bp_taken;
                            iq_pred_d  = nxt_pc;
                            state_d    = ST_IDLE;
                        end else begin
                            hold_instr_d = bus.ic_instr;
                            hold_pc_d    = ic_addr_q;
                            hold_taken_d = bus.bp_taken;
                            hold_nxt_d   = nxt_pc;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    ic_req_d = 1'b0;
                    if (!bus.iq_full) begin
                        iq_push_d  = 1'b1;
                        iq_instr_d = hold_instr_q;
                        iq_pc_d    = hold_pc_q;
                        iq_taken_d = hold_taken_q;
                        iq_pred_d  = hold_nxt_q;
                        state_d    = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    ic_req_d = 1'b0;
                    if (bus.ic_valid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // rdy=0 freezes everything, iq_push included, so a pulse that is
    // frozen is not re-issued once rdy returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ic_req_q     <= 1'b0;
            ic_addr_q    <= RESET_PC;
            iq_push_q    <= 1'b0;
            iq_instr_q   <= '0;
            iq_pc_q      <= '0;
            iq_taken_q   <= 1'b0;
            iq_pred_q    <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            hold_taken_q <= 1'b0;
            hold_nxt_q   <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ic_req_q     <= ic_req_d;
            ic_addr_q    <= ic_addr_d;
            iq_push_q    <= iq_push_d;
            iq_instr_q   <= iq_instr_d;
            iq_pc_q      <= iq_pc_d;
            iq_taken_q   <= iq_taken_d;
            iq_pred_q    <= iq_pred_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            hold_taken_q <= hold_taken_d;
            hold_nxt_q   <= hold_nxt_d;
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the IF stage.
- Holds the architectural fetch PC and issues one request at a time to the instruction cache.
- Presents each returned instruction to the branch predictor and pushes the instruction, its PC and the prediction into the instruction queue.
- Selects the next PC from the prediction; a ROB misprediction flush redirects it.

Parameters:
- RESET_PC, 32'h0, fetch PC loaded on reset.
- DATA_WIDTH, 32, PC and instruction width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; 0 pauses the block.
- ic_req  out  1  fetch request to ICache, registered.
- ic_addr  out  32  fetch address, registered.
- ic_valid  in  1  ICache response valid, one-cycle pulse.
- ic_instr  in  32  returned instruction.
- bp_pc  out  32  PC presented to predictor; combinational, equals ic_addr.
- bp_instr  out  32  instruction presented to predictor; combinational, equals ic_instr.
- bp_taken  in  1  predictor jump decision, combinational from bp_*.
- bp_predict_pc  in  32  predicted target, combinational from bp_*.
- iq_full  in  1  instruction queue cannot accept a push.
- iq_push  out  1  push strobe, one-cycle pulse, registered.
- iq_instr  out  32  pushed instruction.
- iq_pc  out  32  PC of pushed instruction.
- iq_pred_taken  out  1  predicted-taken bit.
- iq_pred_pc  out  32  predicted next PC.
- flush  in  1  ROB misprediction redirect.
- flush_pc  in  32  redirect target.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=RESET_PC, ic_req=0, ic_addr=RESET_PC, iq_push=0, iq_instr/iq_pc/iq_pred_pc=0, iq_pred_taken=0, hold registers cleared.
- rdy=0: every register holds its value, and ic_valid, flush and iq_full are ignored.
  - iq_push keeps its value, so a pulse is never duplicated: iq_push is forced to 0 on any rdy=1 cycle without a new push.
  - Reset overrides rdy.
- All transitions below apply on rdy=1 clock edges.
- IDLE:
  - Set ic_req<=1 and ic_addr<=pc, then go to WAIT.
- WAIT:
  - ic_req stays 1 until ic_valid.
  - On ic_valid, compute nxt = bp_taken ? bp_predict_pc : ic_addr+4 (mod 2^32).
  - If iq_full=0: iq_push<=1, iq_instr<=ic_instr, iq_pc<=ic_addr, iq_pred_taken<=bp_taken, iq_pred_pc<=nxt, pc<=nxt, ic_req<=0, go to IDLE.
  - If iq_full=1: latch instr, PC, taken and nxt into hold registers, pc<=nxt, ic_req<=0, go to HOLD.
- HOLD:
  - ic_req=0.
  - When iq_full=0: push the held values (iq_push<=1), go to IDLE.
- DRAIN:
  - ic_req=0.
  - Wait for the stale ic_valid, discard it (no push, predictor result ignored), go to IDLE.
- Flush has priority over every other event in the same cycle:
  - Set pc<=flush_pc, ic_req<=0, iq_push<=0 and drop any held instruction.
  - In WAIT without ic_valid, go to DRAIN.
  - In WAIT with ic_valid the same cycle, the response is discarded; go to IDLE.
  - In DRAIN, stay in DRAIN (outstanding response still pending).
  - In any other state, go to IDLE.
- Latency:
  - ic_req rises 1 cycle after entering IDLE.
  - iq_push is asserted the cycle after ic_valid.
  - The next ic_req follows 1 cycle after the push.
- At most one ICache request is outstanding; ic_addr is stable while ic_req=1.
- pc wraps modulo 2^32; 0xFFFFFFFC+4 = 0x0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with RESET_PC=0 -> ic_req=0, iq_push=0. Release -> ic_req=1, ic_addr=0x0 one cycle later.
- Sequential fetch: ic_valid 2 cycles after the request, ic_instr=0x00000013, bp_taken=0 -> next cycle iq_push=1, iq_pc=0x0, iq_pred_pc=0x4, iq_pred_taken=0. The following request has ic_addr=0x4.
- Taken prediction: at pc 0x4, bp_taken=1, bp_predict_pc=0x100 -> iq_pred_taken=1, iq_pred_pc=0x100; next ic_addr=0x100.
- Queue full: iq_full=1 when ic_valid arrives, then held for 3 cycles -> no push, ic_req=0. When iq_full falls, a single push of the held instruction and PC follows; the next fetch uses the predicted PC.
- Flush during WAIT: flush=1, flush_pc=0x200 while a request is outstanding -> ic_req=0, state DRAIN. The later ic_valid produces no push; the next ic_addr=0x200.
- Pause and simultaneous events: rdy=0 for 4 cycles with ic_valid pulsed -> no state change and no push. With rdy=1, flush and ic_valid in the same cycle -> no push, next ic_addr=flush_pc, no DRAIN.
